memory_control: RTL and testbench
=================================

MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 SHALL have parameter CPUS, default 2, number of caches served (only 2 supported).
REQ-002 SHALL have port CLK  in  1  system clock; one clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports iREN, dREN, dWEN  in  [CPUS-1:0]  per-cache instruction read, data read, data write requests.
REQ-005 SHALL have ports iaddr, daddr, dstore  in  [CPUS-1:0][31:0]  per-cache addresses and write data.
REQ-006 SHALL have ports ccwrite, cctrans  in  [CPUS-1:0]  read-for-ownership flag; cache holds block in M and is supplying it.
REQ-007 SHALL have ports ramload  in  32  and ramstate  in  2  (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-008 SHALL have ports iwait, dwait  out  [CPUS-1:0]  and iload, dload  out  [CPUS-1:0][31:0]  cache responses.
REQ-009 SHALL have ports ramaddr, ramstore  out  32  and ramREN, ramWEN  out  1  RAM request.
REQ-010 SHALL have ports ccwait, ccinv  out  [CPUS-1:0]  and ccsnoopaddr  out  [CPUS-1:0][31:0]  snoop control.

Function
REQ-011 SHALL implement FSM states IDLE, WB0, WB1, IFETCH, SNOOP, LD0, LD1, C2C0, C2C1; requester c, other o=~c held in a register.
REQ-012 SHALL in IDLE, per cycle, grant first of: any dWEN -> WB0; any dREN -> SNOOP; any iREN -> IFETCH; grant takes effect next edge (1-cycle arbitration latency).
REQ-013 SHALL, when both caches request the same class, pick the winner per REQ-027.
REQ-014 SHALL in WB0/WB1 drive ramWEN=1, ramaddr=daddr[c], ramstore=dstore[c]; on ramstate==ACCESS drive dwait[c]=0 that cycle and advance WB0->WB1->IDLE.
REQ-015 SHALL in IFETCH drive ramREN=1, ramaddr=iaddr[c], iload[c]=ramload; on ACCESS drive iwait[c]=0 and go IDLE (one word).
REQ-016 SHALL in SNOOP drive ccwait[o]=1, ccsnoopaddr[o]=daddr[c], ccinv[o]=ccwrite[c]; stay exactly one cycle, then go C2C0 if cctrans[o]=1, else LD0.
REQ-017 SHALL in LD0/LD1 drive ramREN=1, ramaddr=daddr[c], dload[c]=ramload; on ACCESS drive dwait[c]=0, advance LD0->LD1->IDLE.
REQ-018 SHALL in C2C0/C2C1 drive ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[c]=dstore[o]; on ACCESS drive dwait[c]=0 and dwait[o]=0, advance C2C0->C2C1->IDLE.
REQ-019 SHALL hold ccwait[o], ccinv[o], ccsnoopaddr[o] at SNOOP values through all of SNOOP, LD*, C2C*.
REQ-020 SHALL default, in every state unless driven above: iwait=dwait=all-ones, ccwait=ccinv=0, ccsnoopaddr=0, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0.
REQ-021 SHALL treat ramstate FREE, BUSY, ERROR as not-ready: hold state and request, keep waits high.
REQ-022 SHALL never assert ramREN and ramWEN together.
REQ-023 SHALL ignore new requests outside IDLE; requests withdrawn mid-transaction are not checked (caches hold requests until wait drops).
REQ-024 SHALL, when one cache raises dWEN and dREN together, serve dWEN first.

Reset
REQ-025 SHALL on CLK edge with nRST=0 enter IDLE, clear c and the priority pointer to 0; outputs take REQ-020 defaults combinationally from IDLE.
REQ-026 SHALL, when reset occurs mid-transaction, abandon it without completing the second word; no wait is dropped.

Configuration
REQ-027 SHALL with CC_ROUND_ROBIN_EN defined keep a 1-bit last-granted pointer, update it on return to IDLE, and grant ties to the cache not last granted; without it, cache 0 always wins ties.

Verification
REQ-028 SHALL cover: cache0 iREN, iaddr=0x40, ramload=0x8C010004 after 2 BUSY cycles -> iload[0]=0x8C010004, iwait[0]=0 one cycle, IDLE next.
REQ-029 SHALL cover: cache1 dWEN daddr=0x100/0x104, dstore=0xAAAA/0xBBBB -> two ramWEN writes, dwait[1] low once per word.
REQ-030 SHALL cover: cache0 dREN ccwrite=1 daddr=0x200, cctrans[1]=0 -> ccinv[1]=1, ccsnoopaddr[1]=0x200, two RAM reads to dload[0].
REQ-031 SHALL cover: cache0 dREN, cctrans[1]=1, dstore[1]=0xDEAD -> dload[0]=0xDEAD, ramstore=0xDEAD, dwait[0] and dwait[1] low together.
REQ-032 SHALL cover: both iREN asserted repeatedly -> grants 0,1,0,1 with CC_ROUND_ROBIN_EN; 0,0,0 without.
REQ-033 SHALL cover: nRST=0 during LD1 -> next edge IDLE, all waits high, ramREN=0.

Source files
------------

// File: rtl/memory_control_if.sv
// Cache/RAM-side signal bundle for memory_control, dimensioned by the number of caches.
// slave = the controller's view, master = the caches/RAM view.
interface memory_control_if #(
  parameter int unsigned CPUS = 2
);
  localparam int unsigned DW = 32;

  logic [CPUS-1:0]         iREN;
  logic [CPUS-1:0]         dREN;
  logic [CPUS-1:0]         dWEN;
  logic [CPUS-1:0][DW-1:0] iaddr;
  logic [CPUS-1:0][DW-1:0] daddr;
  logic [CPUS-1:0][DW-1:0] dstore;
  logic [CPUS-1:0]         ccwrite;
  logic [CPUS-1:0]         cctrans;
  logic [DW-1:0]           ramload;
  logic [1:0]              ramstate;

  logic [CPUS-1:0]         iwait;
  logic [CPUS-1:0]         dwait;
  logic [CPUS-1:0][DW-1:0] iload;
  logic [CPUS-1:0][DW-1:0] dload;
  logic [DW-1:0]           ramaddr;
  logic [DW-1:0]           ramstore;
  logic                    ramREN;
  logic                    ramWEN;
  logic [CPUS-1:0]         ccwait;
  logic [CPUS-1:0]         ccinv;
  logic [CPUS-1:0][DW-1:0] ccsnoopaddr;

  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
    output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN,
           ccwait, ccinv, ccsnoopaddr
  );

  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN,
           ccwait, ccinv, ccsnoopaddr
  );
endinterface

// File: rtl/memory_control.sv
// Two-cache coherent memory controller: arbitration, write-back, fetch, snoop and cache-to-cache transfer.
// Define CC_ROUND_ROBIN_EN to alternate tie grants between caches; otherwise cache 0 always wins ties.
module memory_control #(
  parameter int unsigned CPUS = 2
) (
  input logic              CLK,
  input logic              nRST,
  memory_control_if.slave  bus
);
  localparam int unsigned DW         = 32;
  localparam logic [1:0]  RAM_ACCESS = 2'd2;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, IFETCH, SNOOP, LD0, LD1, C2C0, C2C1
  } state_e;

  state_e        state_q, state_d;
  logic          c_q, c_d;
  logic          o_sel;
  logic [DW-1:0] snoop_addr_q, snoop_addr_d;
  logic          snoop_inv_q, snoop_inv_d;
  logic          tie_prio;
  logic          ram_ready;

  logic [CPUS-1:0]         iwait_c, dwait_c, ccwait_c, ccinv_c;
  logic [CPUS-1:0][DW-1:0] iload_c, dload_c, ccsnoopaddr_c;
  logic [DW-1:0]           ramaddr_c, ramstore_c;
  logic                    ramren_c, ramwen_c;

`ifdef CC_ROUND_ROBIN_EN
  logic prio_q, prio_d;
  assign tie_prio = prio_q;
`else
  assign tie_prio = 1'b0;
`endif

  assign o_sel     = ~c_q;
  assign ram_ready = (bus.ramstate == RAM_ACCESS);

  // Winner of one request class; tie_prio names the cache favoured when both ask.
  function automatic logic pick(input logic [CPUS-1:0] req, input logic prio);
    if (&req) return prio;
    return req[1];
  endfunction

  // Next-state and requester selection.
  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    snoop_addr_d = snoop_addr_q;
    snoop_inv_d  = snoop_inv_q;
`ifdef CC_ROUND_ROBIN_EN
    prio_d       = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.dWEN) begin
          c_d     = pick(bus.dWEN, tie_prio);
          state_d = WB0;
        end else if (|bus.dREN) begin
          c_d     = pick(bus.dREN, tie_prio);
          state_d = SNOOP;
        end else if (|bus.iREN) begin
          c_d     = pick(bus.iREN, tie_prio);
          state_d = IFETCH;
        end
      end
      WB0:    if (ram_ready) state_d = WB1;
      WB1:    if (ram_ready) state_d = IDLE;
      IFETCH: if (ram_ready) state_d = IDLE;
      SNOOP: begin
        snoop_addr_d = bus.daddr[c_q];
        snoop_inv_d  = bus.ccwrite[c_q];
        state_d      = bus.cctrans[o_sel] ? C2C0 : LD0;
      end
      LD0:    if (ram_ready) state_d = LD1;
      LD1:    if (ram_ready) state_d = IDLE;
      C2C0:   if (ram_ready) state_d = C2C1;
      C2C1:   if (ram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef CC_ROUND_ROBIN_EN
    if (state_q != IDLE && state_d == IDLE) prio_d = ~c_q;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      c_q          <= 1'b0;
      snoop_addr_q <= '0;
      snoop_inv_q  <= 1'b0;
`ifdef CC_ROUND_ROBIN_EN
      prio_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      snoop_addr_q <= snoop_addr_d;
      snoop_inv_q  <= snoop_inv_d;
`ifdef CC_ROUND_ROBIN_EN
      prio_q       <= prio_d;
`endif
    end
  end

  // Responses follow ramstate in the same cycle, so outputs are decoded from state and inputs.
  always_comb begin
    iwait_c       = '1;
    dwait_c       = '1;
    iload_c       = '0;
    dload_c       = '0;
    ramaddr_c     = '0;
    ramstore_c    = '0;
    ramren_c      = 1'b0;
    ramwen_c      = 1'b0;
    ccwait_c      = '0;
    ccinv_c       = '0;
    ccsnoopaddr_c = '0;
    case (state_q)
      WB0, WB1: begin
        ramwen_c   = 1'b1;
        ramaddr_c  = bus.daddr[c_q];
        ramstore_c = bus.dstore[c_q];
        if (ram_ready) dwait_c[c_q] = 1'b0;
      end
      IFETCH: begin
        ramren_c       = 1'b1;
        ramaddr_c      = bus.iaddr[c_q];
        iload_c[c_q]   = bus.ramload;
        if (ram_ready) iwait_c[c_q] = 1'b0;
      end
      SNOOP: begin
        ccwait_c[o_sel]      = 1'b1;
        ccsnoopaddr_c[o_sel] = bus.daddr[c_q];
        ccinv_c[o_sel]       = bus.ccwrite[c_q];
      end
      LD0, LD1: begin
        ramren_c             = 1'b1;
        ramaddr_c            = bus.daddr[c_q];
        dload_c[c_q]         = bus.ramload;
        ccwait_c[o_sel]      = 1'b1;
        ccsnoopaddr_c[o_sel] = snoop_addr_q;
        ccinv_c[o_sel]       = snoop_inv_q;
        if (ram_ready) dwait_c[c_q] = 1'b0;
      end
      C2C0, C2C1: begin
        // The owning cache's data goes to the requester and back to RAM at once.
        ramwen_c             = 1'b1;
        ramaddr_c            = bus.daddr[o_sel];
        ramstore_c           = bus.dstore[o_sel];
        dload_c[c_q]         = bus.dstore[o_sel];
        ccwait_c[o_sel]      = 1'b1;
        ccsnoopaddr_c[o_sel] = snoop_addr_q;
        ccinv_c[o_sel]       = snoop_inv_q;
        if (ram_ready) begin
          dwait_c[c_q]   = 1'b0;
          dwait_c[o_sel] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.iwait       = iwait_c;
  assign bus.dwait       = dwait_c;
  assign bus.iload       = iload_c;
  assign bus.dload       = dload_c;
  assign bus.ramaddr     = ramaddr_c;
  assign bus.ramstore    = ramstore_c;
  assign bus.ramREN      = ramren_c;
  assign bus.ramWEN      = ramwen_c;
  assign bus.ccwait      = ccwait_c;
  assign bus.ccinv       = ccinv_c;
  assign bus.ccsnoopaddr = ccsnoopaddr_c;
endmodule

// File: tb/tb_memory_control.sv
// Scoreboard bench for memory_control: expected completion beats are queued by the stimulus
// and compared by a monitor whenever any iwait/dwait bit drops.
module tb_memory_control;
  logic CLK;
  logic nRST;

  memory_control_if #(.CPUS(2)) bus ();

  memory_control #(.CPUS(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]        iwait;
    logic [1:0]        dwait;
    logic [1:0][31:0]  iload;
    logic [1:0][31:0]  dload;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    ram_lat = 0;
  bit    ram_hold = 0;
  int    ram_cnt = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM contents: one special word, everything else derived from the address.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb bus.ramload = ram_word(bus.ramaddr);

  // RAM timing: ram_lat BUSY cycles then one ACCESS cycle per requested word.
  always @(posedge CLK) begin
    #1;
    if (ram_hold) begin
      bus.ramstate = 2'd1;
    end else if (bus.ramREN || bus.ramWEN) begin
      if (ram_cnt >= ram_lat) begin
        bus.ramstate = 2'd2;
        ram_cnt = 0;
      end else begin
        bus.ramstate = 2'd1;
        ram_cnt++;
      end
    end else begin
      bus.ramstate = 2'd0;
      ram_cnt = 0;
    end
  end

  function automatic beat_t idle_rec();
    beat_t r;
    r = '0;
    r.iwait = 2'b11;
    r.dwait = 2'b11;
    return r;
  endfunction

  // Monitor: every cycle with a dropped wait is a beat that must match the queue head.
  always @(negedge CLK) begin
    beat_t act, exp;
    if (nRST && (!(&bus.iwait) || !(&bus.dwait))) begin
      act.iwait = bus.iwait;   act.dwait = bus.dwait;
      act.iload = bus.iload;   act.dload = bus.dload;
      act.ramREN = bus.ramREN; act.ramWEN = bus.ramWEN;
      act.ramaddr = bus.ramaddr; act.ramstore = bus.ramstore;
      act.ccwait = bus.ccwait; act.ccinv = bus.ccinv;
      act.ccsnoopaddr = bus.ccsnoopaddr;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h, required no beat", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL beat: got %h required %h", act, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_beat(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      if (!(&bus.iwait) || !(&bus.dwait)) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no wait drop in 60 cycles, required a beat", name);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t e;
    int    seq[4];

    nRST = 1'b0;
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ccwrite = '0; bus.cctrans = '0; bus.ramstate = 2'd0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_waits", 64'({bus.iwait, bus.dwait}), 64'(4'b1111));
    check("rst_ram", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr}), 64'(0));
    check("rst_cc", 64'({bus.ccwait, bus.ccinv, bus.ccsnoopaddr}), 64'(0));
    step();
    nRST = 1'b1;

    // Instruction fetch, cache 0, two BUSY cycles
    ram_lat = 2;
    e = idle_rec(); e.iwait = 2'b10; e.iload[0] = 32'h8C01_0004;
    e.ramREN = 1'b1; e.ramaddr = 32'h40;
    sb.push_back(e);
    step();
    bus.iaddr[0] = 32'h40; bus.iREN[0] = 1'b1;
    wait_beat("ifetch");
    step();
    bus.iREN = '0;
    @(negedge CLK);
    check("idle_after_ifetch", 64'({bus.ramREN, bus.ramWEN, bus.iwait}), 64'(4'b0011));

    // Write-back, cache 1, two words
    ram_lat = 1;
    e = idle_rec(); e.dwait = 2'b01; e.ramWEN = 1'b1; e.ramaddr = 32'h100; e.ramstore = 32'hAAAA;
    sb.push_back(e);
    e.ramaddr = 32'h104; e.ramstore = 32'hBBBB;
    sb.push_back(e);
    step();
    bus.daddr[1] = 32'h100; bus.dstore[1] = 32'hAAAA; bus.dWEN[1] = 1'b1;
    wait_beat("wb_w0");
    step();
    bus.daddr[1] = 32'h104; bus.dstore[1] = 32'hBBBB;
    wait_beat("wb_w1");
    step();
    bus.dWEN = '0; bus.daddr[1] = '0; bus.dstore[1] = '0;

    // Read-for-ownership from RAM; snoop address must stay at the first word
    ram_lat = 0;
    e = idle_rec(); e.dwait = 2'b10; e.ramREN = 1'b1; e.ramaddr = 32'h200;
    e.dload[0] = 32'hA5A5_0200; e.ccwait = 2'b10; e.ccinv = 2'b10; e.ccsnoopaddr[1] = 32'h200;
    sb.push_back(e);
    e.ramaddr = 32'h204; e.dload[0] = 32'hA5A5_0204;
    sb.push_back(e);
    step();
    bus.daddr[0] = 32'h200; bus.ccwrite[0] = 1'b1; bus.dREN[0] = 1'b1;
    wait_beat("ld_w0");
    step();
    bus.daddr[0] = 32'h204;
    wait_beat("ld_w1");
    step();
    bus.dREN = '0; bus.ccwrite = '0; bus.daddr[0] = '0;

    // Cache-to-cache transfer from cache 1 in M
    ram_lat = 1;
    e = idle_rec(); e.dwait = 2'b00; e.ramWEN = 1'b1; e.ramaddr = 32'h300; e.ramstore = 32'hDEAD;
    e.dload[0] = 32'hDEAD; e.ccwait = 2'b10; e.ccsnoopaddr[1] = 32'h300;
    sb.push_back(e);
    e.ramaddr = 32'h304; e.ramstore = 32'hBEEF; e.dload[0] = 32'hBEEF;
    sb.push_back(e);
    step();
    bus.daddr[0] = 32'h300; bus.daddr[1] = 32'h300; bus.dstore[1] = 32'hDEAD;
    bus.cctrans[1] = 1'b1; bus.dREN[0] = 1'b1;
    wait_beat("c2c_w0");
    step();
    bus.daddr[0] = 32'h304; bus.daddr[1] = 32'h304; bus.dstore[1] = 32'hBEEF;
    wait_beat("c2c_w1");
    step();
    bus.dREN = '0; bus.cctrans = '0; bus.daddr = '0; bus.dstore = '0;

    // Same cache raising dWEN and dREN: the write goes first
    ram_lat = 0;
    e = idle_rec(); e.dwait = 2'b10; e.ramWEN = 1'b1; e.ramaddr = 32'h500; e.ramstore = 32'h55;
    sb.push_back(e);
    sb.push_back(e);
    step();
    bus.daddr[0] = 32'h500; bus.dstore[0] = 32'h55; bus.dWEN[0] = 1'b1; bus.dREN[0] = 1'b1;
    wait_beat("wr_first_w0");
    wait_beat("wr_first_w1");
    step();
    bus.dWEN = '0; bus.dREN = '0; bus.daddr = '0; bus.dstore = '0;

    // Reset during the second load word abandons it
    ram_lat = 0;
    e = idle_rec(); e.dwait = 2'b10; e.ramREN = 1'b1; e.ramaddr = 32'h600;
    e.dload[0] = 32'hA5A5_0600; e.ccwait = 2'b10; e.ccsnoopaddr[1] = 32'h600;
    sb.push_back(e);
    step();
    bus.daddr[0] = 32'h600; bus.dREN[0] = 1'b1;
    wait_beat("rst_ld_w0");
    ram_hold = 1'b1;
    step();
    nRST = 1'b0;
    step();
    nRST = 1'b1; bus.dREN = '0; bus.daddr = '0; ram_hold = 1'b0;
    @(negedge CLK);
    check("rst_mid_waits", 64'({bus.iwait, bus.dwait}), 64'(4'b1111));
    check("rst_mid_ramren", 64'({bus.ramREN, bus.ramWEN}), 64'(0));
    check("rst_mid_cc", 64'({bus.ccwait, bus.ccinv}), 64'(0));

    // Both caches fetching repeatedly: tie arbitration order
`ifdef CC_ROUND_ROBIN_EN
    seq = '{0, 1, 0, 1};
`else
    seq = '{0, 0, 0, 0};
`endif
    ram_lat = 0;
    for (int k = 0; k < 4; k++) begin
      e = idle_rec(); e.ramREN = 1'b1;
      if (seq[k] == 0) begin
        e.iwait = 2'b10; e.iload[0] = 32'hA5A5_0010; e.ramaddr = 32'h10;
      end else begin
        e.iwait = 2'b01; e.iload[1] = 32'hA5A5_0020; e.ramaddr = 32'h20;
      end
      sb.push_back(e);
    end
    step();
    bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20; bus.iREN = 2'b11;
    for (int k = 0; k < 4; k++) wait_beat("tie_fetch");
    step();
    bus.iREN = '0;

    repeat (5) @(negedge CLK);
    check("sb_drain", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
